// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: each functional unit feeds a small result FIFO, and a
// round-robin arbiter broadcasts one FIFO head per cycle on a registered CDB.
module cdb_fu_fifo #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 valid,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic [BIT_WIDTH-1:0] value,
    input  logic                 pop,
    output logic                 ready,
    output logic                 nonempty,
    output logic [TAG_WIDTH-1:0] head_tag,
    output logic [BIT_WIDTH-1:0] head_value
);
    localparam int PW = $clog2(BUF_DEPTH);

    logic [TAG_WIDTH-1:0] tag_mem   [BUF_DEPTH];
    logic [BIT_WIDTH-1:0] value_mem [BUF_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 push;

    // Ready comes from the registered count only, so a full buffer stays closed
    // even on the edge where its head is being popped.
    assign ready      = count < (PW+1)'(BUF_DEPTH);
    assign nonempty   = count != '0;
    assign push       = valid && ready;
    assign head_tag   = tag_mem[rd_ptr];
    assign head_value = value_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            tag_mem[wr_ptr]   <= tag;
            value_mem[wr_ptr] <= value;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int BIT_WIDTH = 32,
    parameter int TAG_WIDTH = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_valid,
    input  logic [NUM_FU-1:0][TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUM_FU-1:0][BIT_WIDTH-1:0]  fu_result,
    output logic [NUM_FU-1:0]                 fu_ready,
    output logic                              cdb_valid,
    output logic [TAG_WIDTH-1:0]              cdb_tag,
    output logic [BIT_WIDTH-1:0]              cdb_value,
    output logic [$clog2(NUM_FU)-1:0]         cdb_src
);
    localparam int SRC_W = $clog2(NUM_FU);
    localparam int IDX_W = SRC_W + 1;

    logic [NUM_FU-1:0]                nonempty, pop;
    logic [NUM_FU-1:0][TAG_WIDTH-1:0] head_tag;
    logic [NUM_FU-1:0][BIT_WIDTH-1:0] head_value;
    logic [SRC_W-1:0]                 rr_ptr, winner, rr_next;
    logic                             found;

    generate
        for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
            cdb_fu_fifo #(
                .BIT_WIDTH(BIT_WIDTH),
                .TAG_WIDTH(TAG_WIDTH),
                .BUF_DEPTH(BUF_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .valid     (fu_valid[i]),
                .tag       (fu_tag[i]),
                .value     (fu_result[i]),
                .pop       (pop[i]),
                .ready     (fu_ready[i]),
                .nonempty  (nonempty[i]),
                .head_tag  (head_tag[i]),
                .head_value(head_value[i])
            );
            assign pop[i] = found && !flush && (winner == SRC_W'(i));
        end
    endgenerate

    // Scan from rr_ptr upward; the wrap is a compare so non-power-of-two NUM_FU works.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_FU)) idx = idx - IDX_W'(NUM_FU);
            if (!found && nonempty[idx[SRC_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[SRC_W-1:0];
            end
        end
    end

    assign rr_next = (winner == SRC_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head_tag[winner];
            cdb_value <= head_value[winner];
            cdb_src   <= winner;
            rr_ptr    <= rr_next;
        end else begin
            cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-FU scoreboard queues plus a round-robin
// reference predict every broadcast and every fu_ready value.
module tb_cdb_arbiter;
    localparam int NUM_FU    = 4;
    localparam int BIT_WIDTH = 32;
    localparam int TAG_WIDTH = 8;
    localparam int BUF_DEPTH = 2;
    localparam int SRC_W     = $clog2(NUM_FU);

    logic                             clk, reset, flush;
    logic [NUM_FU-1:0]                fu_valid, fu_ready;
    logic [NUM_FU-1:0][TAG_WIDTH-1:0] fu_tag;
    logic [NUM_FU-1:0][BIT_WIDTH-1:0] fu_result;
    logic                             cdb_valid;
    logic [TAG_WIDTH-1:0]             cdb_tag;
    logic [BIT_WIDTH-1:0]             cdb_value;
    logic [SRC_W-1:0]                 cdb_src;

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .BIT_WIDTH(BIT_WIDTH), .TAG_WIDTH(TAG_WIDTH), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int rr       = 0;
    logic [TAG_WIDTH+BIT_WIDTH-1:0] sb [NUM_FU][$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock: drive v/fl, predict acceptance and winner, then check outputs #1 after the edge.
    task automatic tick(input logic [NUM_FU-1:0] v, input logic fl, output logic [NUM_FU-1:0] acc);
        logic any;
        int win;
        logic [TAG_WIDTH+BIT_WIDTH-1:0] item;
        logic [NUM_FU-1:0] exp_ready;
        fu_valid = v;
        flush    = fl;
        any = 1'b0; win = 0; item = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!any && sb[(rr + k) % NUM_FU].size() > 0) begin
                any = 1'b1;
                win = (rr + k) % NUM_FU;
            end
        end
        for (int i = 0; i < NUM_FU; i++) acc[i] = v[i] && (sb[i].size() < BUF_DEPTH) && !fl;
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < NUM_FU; i++) sb[i].delete();
            rr = 0;
        end else begin
            if (any) begin
                item = sb[win].pop_front();
                rr = (win + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++)
                if (acc[i]) sb[i].push_back({fu_tag[i], fu_result[i]});
        end
        #1;
        chk("cdb_valid", cdb_valid, any && !fl);
        if (any && !fl) begin
            chk("cdb_src", cdb_src, win);
            chk("cdb_tag", cdb_tag, item[BIT_WIDTH +: TAG_WIDTH]);
            chk("cdb_value", cdb_value, item[BIT_WIDTH-1:0]);
        end
        for (int i = 0; i < NUM_FU; i++) exp_ready[i] = sb[i].size() < BUF_DEPTH;
        chk("fu_ready", fu_ready, exp_ready);
    endtask

    function automatic logic model_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NUM_FU; i++) if (sb[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain();
        logic [NUM_FU-1:0] a;
        for (int k = 0; k < 16 && !model_empty(); k++) tick('0, 1'b0, a);
        tick('0, 1'b0, a);
    endtask

    initial begin
        logic [NUM_FU-1:0] acc, v;
        int n0, n1;
        reset = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_result = '0;

        // reset values while reset is held
        #2 reset = 1'b1;
        #2;
        chk("rst_ready", fu_ready, {NUM_FU{1'b1}});
        chk("rst_valid", cdb_valid, 1'b0);
        chk("rst_tag", cdb_tag, 0);
        chk("rst_value", cdb_value, 0);
        chk("rst_src", cdb_src, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // single result from FU2
        fu_tag[2] = 8'h15; fu_result[2] = 32'hDEADBEEF;
        tick(4'b0100, 1'b0, acc);
        tick(4'b0000, 1'b0, acc);
        chk("single_src", cdb_src, 2);
        chk("single_tag", cdb_tag, 8'h15);
        tick(4'b0000, 1'b0, acc);
        chk("single_idle", cdb_valid, 1'b0);

        // round robin from a cleared pointer
        tick(4'b0000, 1'b1, acc);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i] = 8'(8'h10 + i); fu_result[i] = 32'(32'h1000 + i);
        end
        tick(4'b1111, 1'b0, acc);
        for (int i = 0; i < NUM_FU; i++) begin
            tick(4'b0000, 1'b0, acc);
            chk("rr_order", cdb_src, i);
        end
        fu_tag[0] = 8'h30; fu_result[0] = 32'h3000;
        fu_tag[3] = 8'h33; fu_result[3] = 32'h3333;
        tick(4'b1001, 1'b0, acc);
        tick(4'b0000, 1'b0, acc);
        chk("rr_wrap_first", cdb_src, 0);
        tick(4'b0000, 1'b0, acc);
        chk("rr_wrap_second", cdb_src, 3);
        tick(4'b0000, 1'b0, acc);

        // backpressure: FU1 offers three results while FU0 streams
        n0 = 0; n1 = 0;
        for (int c = 0; c < 12 && n1 < 3; c++) begin
            fu_tag[0] = 8'(8'h40 + n0); fu_result[0] = 32'(32'hA000 + n0);
            fu_tag[1] = 8'(8'h20 + n1); fu_result[1] = 32'(32'hB000 + n1);
            v = '0; v[0] = 1'b1; v[1] = (n1 < 3);
            tick(v, 1'b0, acc);
            if (acc[0]) n0++;
            if (acc[1]) n1++;
        end
        chk("bp_fu1_all_accepted", n1, 3);
        drain();

        // simultaneous push and pop on FU0
        fu_tag[0] = 8'h50; fu_result[0] = 32'h5050;
        tick(4'b0001, 1'b0, acc);
        fu_tag[0] = 8'h51; fu_result[0] = 32'h5151;
        tick(4'b0001, 1'b0, acc);
        chk("pp_ready0", fu_ready[0], 1'b1);
        chk("pp_head_tag", cdb_tag, 8'h50);
        tick(4'b0000, 1'b0, acc);
        chk("pp_new_tag", cdb_tag, 8'h51);
        tick(4'b0000, 1'b0, acc);

        // fill, then flush with every FU still offering
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                fu_tag[i] = 8'(8'h60 + 4 * c + i); fu_result[i] = 32'(32'h6000 + 4 * c + i);
            end
            tick(4'b1111, 1'b0, acc);
        end
        for (int i = 0; i < NUM_FU; i++) fu_tag[i] = 8'(8'h70 + i);
        tick(4'b1111, 1'b1, acc);
        chk("flush_valid", cdb_valid, 1'b0);
        chk("flush_ready", fu_ready, {NUM_FU{1'b1}});
        tick(4'b0000, 1'b0, acc);
        chk("flush_no_push", cdb_valid, 1'b0);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i] = 8'(8'h80 + i); fu_result[i] = 32'(32'h8000 + i);
        end
        tick(4'b1111, 1'b0, acc);
        tick(4'b0000, 1'b0, acc);
        chk("flush_first_src", cdb_src, 0);
        drain();

        // async reset while a result is on the bus
        fu_tag[1] = 8'h91; fu_result[1] = 32'h9191;
        fu_tag[2] = 8'h92; fu_result[2] = 32'h9292;
        tick(4'b0110, 1'b0, acc);
        tick(4'b0000, 1'b0, acc);
        chk("ar_pre_valid", cdb_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("ar_ready", fu_ready, {NUM_FU{1'b1}});
        chk("ar_valid", cdb_valid, 1'b0);
        chk("ar_tag", cdb_tag, 0);
        chk("ar_value", cdb_value, 0);
        chk("ar_src", cdb_src, 0);
        for (int i = 0; i < NUM_FU; i++) sb[i].delete();
        rr = 0;
        #1 reset = 1'b0;
        tick(4'b0000, 1'b0, acc);
        tick(4'b0000, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter between the functional units and the reservation stations. Each functional unit pushes a completed result (tag, value) into its own small output buffer. A round-robin arbiter selects one buffered result per cycle and broadcasts it on a single registered CDB. The CDB drives the reservation stations' `funcUnitTags`/`funcUnitOut`/`valueReady` inputs.

## Interface
- `NUM_FU`, 4: number of functional units (at least 2).
- `BIT_WIDTH`, 32: result value width.
- `TAG_WIDTH`, 8: result tag width. Tag 0 is legal and gets no special treatment.
- `BUF_DEPTH`, 2: entries per FU output buffer (power of two, at least 2).

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all buffered and pending results.
- `fu_valid` in [NUM_FU]: FU i presents a result this cycle.
- `fu_tag` in [TAG_WIDTH] x NUM_FU: tag of FU i's result.
- `fu_result` in [BIT_WIDTH] x NUM_FU: value of FU i's result.
- `fu_ready` out [NUM_FU]: FU i's buffer can accept this cycle.
- `cdb_valid` out 1: CDB carries a result this cycle.
- `cdb_tag` out [TAG_WIDTH]: broadcast tag.
- `cdb_value` out [BIT_WIDTH]: broadcast value.
- `cdb_src` out [$clog2(NUM_FU)]: index of the FU whose result is on the CDB.

## Operation
- **Per-FU FIFO.** Each FU has a FIFO of `BUF_DEPTH` entries, holding {tag, value} plus a count register of width $clog2(BUF_DEPTH)+1.
- **Ready.** `fu_ready[i]` = (count_i < BUF_DEPTH). It is decoded from the registered count only and has no combinational dependence on the same-cycle pop.
- **Push.** A push occurs when `fu_valid[i]` and `fu_ready[i]` are both high at an edge. If `fu_valid[i]` is high while `fu_ready[i]` is low, the result is ignored; the FU must hold it and retry.
- **Arbitration.** Combinational over the FIFO heads with count_i > 0. The winner is the first non-empty FU at index rr_ptr, rr_ptr+1, … (mod NUM_FU).
- **Winner handling.** The winner's head is popped at the next edge and loaded into the CDB output register (`cdb_valid`=1, tag, value, `cdb_src`). rr_ptr becomes (winner+1) mod NUM_FU.
- **No requester.** If no FU is non-empty, `cdb_valid` goes to 0 at the next edge, the tag/value/src registers hold their previous values, and rr_ptr is unchanged.
- **Simultaneous push and pop on one FU.** The count is unchanged and the FIFO order is preserved. This is legal only when the buffer was not full, because of the ready rule.
- **Pointer arithmetic.** FIFO read/write pointers are $clog2(BUF_DEPTH) bits and wrap naturally. rr_ptr wraps from NUM_FU-1 to 0. For non-power-of-two NUM_FU, the wrap is an explicit compare, not a truncation.
- **Flush.** `flush` sampled high at an edge does the following, and takes priority over any push or pop on that edge:
  - all counts and pointers go to 0;
  - `cdb_valid` goes to 0;
  - rr_ptr goes to 0.
- **Reset.** Reset (async) forces the same state as flush. In addition, `cdb_tag`, `cdb_value` and `cdb_src` reset to 0.
- **Ordering.** Results from the same FU are broadcast in push order. Ordering across FUs is defined only by the arbitration.

## Timing
- **Minimum latency.** A push at edge k can be broadcast at the earliest with `cdb_valid` high in the cycle after edge k+1, i.e. 2 edges from acceptance. There is no bypass from `fu_*` to the CDB.
- **Throughput.** One broadcast per cycle is sustained while any buffer is non-empty.
- **Fairness.** A continuously non-empty FU waits at most NUM_FU-1 broadcasts between its own broadcasts.
- **Outputs while in reset:**
  - `fu_ready` = all 1s;
  - `cdb_valid` = 0;
  - `cdb_tag` = 0;
  - `cdb_value` = 0;
  - `cdb_src` = 0.
- **Reset deassertion.** Pushes are accepted from the first rising edge after `reset` deasserts.
- **Reset mid-operation.** All buffered results are lost. `cdb_valid` drops immediately, asynchronously, without waiting for an edge.
- **Flush timing.** `fu_ready` returns to all 1s in the cycle after the flush edge.

## Test plan
- **Single result.** Reset, then FU2 pushes tag 0x15, value 0xDEADBEEF at edge 1.
  - Required: `cdb_valid`=1, tag 0x15, value 0xDEADBEEF, `cdb_src`=2 after edge 2.
  - Required: `cdb_valid`=0 after edge 3.
- **Round-robin.** All 4 FUs push tags 0x10..0x13 at the same edge.
  - Required: broadcasts on 4 consecutive cycles in src order 0,1,2,3.
  - Then FU3 and FU0 push again at one edge. Required order: 0 then 3 (rr_ptr wrapped to 0).
- **Full/backpressure.** FU1 pushes on 3 consecutive edges while FU0 pushes continuously.
  - Required: FU1's third result is accepted only after `fu_ready[1]` returns high.
  - Required: FU1 results appear in push order with no loss or duplication, checked by a scoreboard on tags.
- **Simultaneous push/pop.** FU0 holds 1 entry and pushes again on the edge where its head wins.
  - Required: count stays 1, `fu_ready[0]` stays 1, next broadcast is the new entry.
- **Flush.** Fill all buffers to BUF_DEPTH, then assert `flush` together with `fu_valid`=all.
  - Required: no pushes accepted on that edge.
  - Required: `cdb_valid`=0 and `fu_ready`=all 1s the next cycle; the first subsequent broadcast comes from FU0.
- **Async reset mid-broadcast.** Assert `reset` between edges while `cdb_valid`=1.
  - Required: all outputs reach reset values before the next edge.
  - Required: no stale result is broadcast after deassertion.
